twiddle_sequencer: RTL
======================

TWIDDLE_SEQUENCER -- requirements
Module: twiddle_sequencer

Interface
REQ-001 SHALL have parameter LOG2N, default 10, meaning log2 of FFT size N (N = 2^LOG2N).
REQ-002 SHALL have parameter MULT_LATENCY, default 3, meaning the twiddle multiplier pipeline depth in cycles.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a full FFT pass.
REQ-006 SHALL have port stall  input  1  holds issue while high.
REQ-007 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse at pass completion.
REQ-009 SHALL have port stage  output  $clog2(LOG2N)  current stage index.
REQ-010 SHALL have port issue_valid  output  1  butterfly operands issued this cycle.
REQ-011 SHALL have port addr_a  output  LOG2N  sample-memory read address, upper operand.
REQ-012 SHALL have port addr_b  output  LOG2N  sample-memory read address, lower operand (multiplied).
REQ-013 SHALL have port tw_addr  output  LOG2N-1  twiddle ROM address.
REQ-014 SHALL have port wb_valid  output  1  issue_valid delayed by MULT_LATENCY; aligns with multiplier output.
REQ-015 SHALL have port wb_addr_a  output  LOG2N  addr_a delayed by MULT_LATENCY.
REQ-016 SHALL have port wb_addr_b  output  LOG2N  addr_b delayed by MULT_LATENCY.

Function
REQ-017 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-018 IDLE: start=1 -> ISSUE next cycle; stage=0; butterfly counter k=0.
REQ-019 ISSUE: when stall=0, issue_valid=1 and k increments; when stall=1, issue_valid=0 and k, addresses hold.
REQ-020 Address rule for stage s and butterfly k: span=2^s, pos=k mod span, group=k>>s, addr_a=group*2*span+pos, addr_b=addr_a+span, tw_addr=pos<<(LOG2N-1-s).
REQ-021 ISSUE -> DRAIN in the cycle after issuing k=N/2-1, with k wrapping to 0.
REQ-022 DRAIN SHALL last exactly MULT_LATENCY cycles (counter), leaving no in-flight butterfly before the next stage reads; stall is ignored in DRAIN.
REQ-023 DRAIN end: if stage<LOG2N-1, stage increments -> ISSUE; else -> DONE.
REQ-024 DONE: done=1 for one cycle, busy=0 -> IDLE.
REQ-025 start while not IDLE SHALL be ignored; start in the DONE cycle ignored.
REQ-026 The delay line SHALL be free-running (no stall gating), matching the unenabled multiplier pipeline; wb_* valid only when wb_valid=1.
REQ-027 With stall=0, pass length SHALL be LOG2N*(N/2+MULT_LATENCY) cycles of ISSUE/DRAIN; done asserts the cycle after.

Reset
REQ-028 rst=1 SHALL asynchronously force state IDLE, k=0, stage=0, busy=0, done=0, issue_valid=0, all addresses 0, and clear every delay-line stage (wb_valid=0).
REQ-029 Reset mid-pass SHALL abandon the pass; no done pulse; next start begins at stage 0.

Structure
REQ-030 State encodings and default MULT_LATENCY SHALL live in shared header fft_defs.vh.
REQ-031 One sub-module SHALL be used: fft_delay_line (parameterised width/depth, async-reset shift register) for wb_valid/wb_addr_a/wb_addr_b.
REQ-032 Address generation SHALL be registered outputs; no combinational path from start/stall to outputs.

Verification (LOG2N=4, MULT_LATENCY=3)
REQ-033 start at cycle 0, stall=0 -> cycle 1: issue_valid=1, addr_a=0, addr_b=1, tw_addr=0; done pulses at cycle 45.
REQ-034 Stage 1, k=1 -> addr_a=1, addr_b=3, tw_addr=4; stage 3, k=5 -> addr_a=5, addr_b=13, tw_addr=5.
REQ-035 stall=1 for 5 cycles mid stage 2 -> issue_valid=0 those cycles, addresses held; done delayed exactly 5 cycles (cycle 50).
REQ-036 Each issue -> wb_valid exactly 3 cycles later with matching wb_addr_a/b; no issue_valid between last issue of a stage and 3 cycles later.
REQ-037 rst pulse at cycle 20 -> all outputs 0 immediately, no done; start at cycle 25 -> done at cycle 70.
REQ-038 start held high for 10 cycles -> exactly one pass; busy continuous; single done pulse.

Source files
------------

// File: rtl/twiddle_sequencer_pkg.sv
// Shared definitions for the FFT twiddle/address sequencer.
package twiddle_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int unsigned MULT_LATENCY_DEFAULT = 3;

endpackage

// File: rtl/twiddle_sequencer_delay_line.sv
// Free-running shift register with asynchronous clear.
// Delays a bus by DEPTH clock cycles.
module fft_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  // Shift one stage per clock; reset clears every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/twiddle_sequencer.sv
// Radix-2 FFT butterfly sequencer: walks every stage, issuing operand and
// twiddle addresses, drains the multiplier between stages, then pulses done.
module twiddle_sequencer
  import twiddle_sequencer_pkg::*;
#(
  parameter int unsigned LOG2N        = 10,
  parameter int unsigned MULT_LATENCY = MULT_LATENCY_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stall,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LOG2N)-1:0] stage,
  output logic                     issue_valid,
  output logic [LOG2N-1:0]         addr_a,
  output logic [LOG2N-1:0]         addr_b,
  output logic [LOG2N-2:0]         tw_addr,
  output logic                     wb_valid,
  output logic [LOG2N-1:0]         wb_addr_a,
  output logic [LOG2N-1:0]         wb_addr_b
);

  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned DW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(MULT_LATENCY - 1);

  seq_state_e      state, state_n;
  logic [SW-1:0]   stage_n;
  logic [KW-1:0]   k, k_n;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic            issue_now;
  logic            iv_n;
  logic [LOG2N-1:0] a_n, b_n;
  logic [KW-1:0]   tw_n;
  logic [LOG2N-1:0] kx, lo_mask;
  int unsigned     sh;

  // Next-state logic; outputs are computed one cycle ahead so every
  // address/valid output comes straight from a flop. k counts the next
  // butterfly to issue, so k==0 with issue_valid set marks the last issue.
  always_comb begin
    state_n   = state;
    stage_n   = stage;
    k_n       = k;
    dcnt_n    = dcnt;
    issue_now = 1'b0;
    iv_n      = 1'b0;
    a_n       = addr_a;
    b_n       = addr_b;
    tw_n      = tw_addr;
    kx        = '0;
    lo_mask   = '0;
    sh        = 0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = ISSUE;
          stage_n   = '0;
          k_n       = '0;
          issue_now = !stall;
        end
      end
      ISSUE: begin
        if (issue_valid && k == '0) begin
          state_n = DRAIN;
          dcnt_n  = '0;
        end else begin
          issue_now = !stall;
        end
      end
      DRAIN: begin
        if (dcnt == LAST_DRAIN) begin
          dcnt_n = '0;
          if (stage == LAST_STAGE) begin
            state_n = DONE;
          end else begin
            state_n   = ISSUE;
            stage_n   = stage + 1'b1;
            issue_now = !stall;
          end
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        stage_n = '0;
      end
      default: state_n = IDLE;
    endcase

    // addr_a is k with a zero bit inserted at position stage; addr_b sets it.
    if (issue_now) begin
      sh      = 32'(stage_n);
      kx      = {1'b0, k_n};
      lo_mask = {LOG2N{1'b1}} >> (LOG2N - sh);
      a_n     = ((kx >> sh) << (sh + 1)) | (kx & lo_mask);
      b_n     = a_n | (LOG2N'(1) << sh);
      tw_n    = KW'(kx & lo_mask) << (LOG2N - 1 - sh);
      iv_n    = 1'b1;
      k_n     = k_n + 1'b1;
    end
  end

  // State, counters and registered issue outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      stage       <= '0;
      k           <= '0;
      dcnt        <= '0;
      issue_valid <= 1'b0;
      addr_a      <= '0;
      addr_b      <= '0;
      tw_addr     <= '0;
    end else begin
      state       <= state_n;
      stage       <= stage_n;
      k           <= k_n;
      dcnt        <= dcnt_n;
      issue_valid <= iv_n;
      addr_a      <= a_n;
      addr_b      <= b_n;
      tw_addr     <= tw_n;
    end
  end

  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = (state == DONE);

  fft_delay_line #(
    .WIDTH(2 * LOG2N + 1),
    .DEPTH(MULT_LATENCY)
  ) u_wb_delay (
    .clk(clk),
    .rst(rst),
    .d  ({issue_valid, addr_a, addr_b}),
    .q  ({wb_valid, wb_addr_a, wb_addr_b})
  );

endmodule
